sprite_scheduler: RTL and testbench

//   Per-frame sequencer for the sprite_render datapath. Holds a double-buffered table of
//   N_SPRITES sprite descriptors, and on each frame_start draws every valid slot in

---
 rtl/sprite_scheduler.sv | 137 +++++++++++++
 tb/tb_sprite_scheduler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_scheduler.sv
// Per-frame sprite sequencer: double-buffered descriptor table that walks
// valid slots in ascending order and drives one sprite_render pass per slot.
module sprite_scheduler #(
  parameter int CORDW     = 10,
  parameter int N_SPRITES = 16,
  parameter int SPR_IDW   = 4,
  parameter int TIMEOUT   = 70000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frame_start,
  input  logic                           wr_en,
  input  logic [$clog2(N_SPRITES)-1:0]   wr_slot,
  input  logic [SPR_IDW+8+2*CORDW:0]     wr_data,
  output logic                           r_rst,
  output logic                           r_enable,
  input  logic                           r_finished,
  output logic [CORDW-1:0]               r_sx,
  output logic [CORDW-1:0]               r_sy,
  output logic [7:0]                     r_scale,
  output logic [SPR_IDW-1:0]             r_id,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           overrun,
  output logic                           timeout_err
);

  localparam int SW = $clog2(N_SPRITES);
  localparam int DW = SPR_IDW + 8 + 2*CORDW;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, SCAN, SETUP, RUN, DONE
  } state_t;

  state_t state, state_n;

  logic [SW-1:0]        slot;
  logic [WW-1:0]        wdog;
  logic [N_SPRITES-1:0] sh_vld, act_vld;
  logic [DW-1:0]        sh_data  [N_SPRITES];
  logic [DW-1:0]        act_data [N_SPRITES];

  logic [DW-1:0]      cur;
  logic [7:0]         cur_scale;
  logic [SPR_IDW-1:0] cur_id;
  logic               hit, last, wd_exp, accept;

  assign cur       = act_data[slot];
  assign cur_scale = cur[2*CORDW +: 8];
  assign cur_id    = cur[2*CORDW+8 +: SPR_IDW];
  assign hit       = act_vld[slot] && (cur_scale != 8'd0);
  assign last      = (slot == SW'(N_SPRITES-1));
  assign wd_exp    = (wdog == WW'(TIMEOUT-1));
  assign accept    = (state == IDLE) && frame_start;
  assign busy      = (state != IDLE);

  always_comb begin
    state_n    = state;
    r_rst      = 1'b0;
    r_enable   = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: if (frame_start) state_n = SCAN;
      SCAN: begin
        if (hit)       state_n = SETUP;
        else if (last) state_n = DONE;
      end
      SETUP: begin
        r_rst   = 1'b1;
        state_n = RUN;
      end
      RUN: begin
        r_enable = 1'b1;
        if (r_finished || wd_exp)
          state_n = last ? DONE : SCAN;
      end
      DONE: begin
        frame_done = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Descriptor payloads carry no reset; the valid vectors gate them.
  always_ff @(posedge clk) begin
    if (wr_en) sh_data[wr_slot] <= wr_data[DW-1:0];
    if (accept) act_data <= sh_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      slot        <= '0;
      wdog        <= '0;
      sh_vld      <= '0;
      act_vld     <= '0;
      r_sx        <= '0;
      r_sy        <= '0;
      r_scale     <= '0;
      r_id        <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      overrun     <= frame_start && (state != IDLE);
      timeout_err <= (state == RUN) && !r_finished && wd_exp;
      if (wr_en) sh_vld[wr_slot] <= wr_data[DW];
      unique case (state)
        IDLE: if (frame_start) begin
          act_vld <= sh_vld;
          slot    <= '0;
        end
        SCAN: begin
          if (hit) begin
            r_sx    <= cur[0 +: CORDW];
            r_sy    <= cur[CORDW +: CORDW];
            r_scale <= cur_scale;
            r_id    <= cur_id;
          end else if (!last) begin
            slot <= slot + SW'(1);
          end
        end
        SETUP: wdog <= '0;
        RUN: begin
          wdog <= wdog + WW'(1);
          if ((r_finished || wd_exp) && !last)
            slot <= slot + SW'(1);
        end
        DONE: slot <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed bench for sprite_scheduler with a small renderer model.
// Watchdog is shortened so abort paths run quickly.
module tb_sprite_scheduler;

  localparam int TMO = 300;

  logic        clk = 1'b0;
  logic        rst, frame_start, wr_en, r_finished;
  logic [3:0]  wr_slot;
  logic [32:0] wr_data;
  logic        r_rst, r_enable, busy, frame_done, overrun, timeout_err;
  logic [9:0]  r_sx, r_sy;
  logic [7:0]  r_scale;
  logic [3:0]  r_id;

  int total = 0;
  int bad   = 0;

  int n_rst, n_done, n_ovr, n_tmo, n_en, clash, done_cyc, done_seen;
  int busy_after, en_after;
  int sx_q[$];

  sprite_scheduler #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .wr_en(wr_en), .wr_slot(wr_slot), .wr_data(wr_data),
    .r_rst(r_rst), .r_enable(r_enable), .r_finished(r_finished),
    .r_sx(r_sx), .r_sy(r_sy), .r_scale(r_scale), .r_id(r_id),
    .busy(busy), .frame_done(frame_done), .overrun(overrun),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int s, input logic v, input int id,
                    input int sc, input int x, input int y);
    wr_en   = 1'b1;
    wr_slot = 4'(s);
    wr_data = {v, 4'(id), 8'(sc), 10'(y), 10'(x)};
    step();
    wr_en = 1'b0;
  endtask

  // Pulse frame_start, model a renderer finishing after fin RUN cycles
  // (0 = never), optionally re-pulse frame_start at cycle fs_at.
  task automatic run_frame(input int fin, input int fs_at);
    int rcnt, tail;
    n_rst = 0; n_done = 0; n_ovr = 0; n_tmo = 0; n_en = 0;
    clash = 0; done_cyc = 0; done_seen = 0;
    sx_q.delete();
    rcnt = 0; tail = 0;
    frame_start = 1'b1;
    for (int cyc = 1; cyc <= 3000 && tail < 4; cyc++) begin
      step();
      frame_start = (cyc == fs_at);
      wr_en = 1'b0;
      if (r_rst && r_enable) clash++;
      if (r_rst) begin
        n_rst++;
        sx_q.push_back(int'(r_sx));
        rcnt = 0;
      end
      if (r_enable) begin
        rcnt++;
        n_en++;
      end
      n_ovr += int'(overrun);
      n_tmo += int'(timeout_err);
      if (frame_done) begin
        n_done++;
        if (done_seen == 0) done_cyc = cyc;
        done_seen = 1;
      end
      if (done_seen != 0) tail++;
      r_finished = (fin != 0) && r_enable && (rcnt == fin);
    end
    chk("frame_bound", done_seen, 1);
    busy_after = int'(busy);
    en_after   = int'(r_enable);
  endtask

  initial begin
    int n;
    rst = 1'b1; frame_start = 1'b0; wr_en = 1'b0;
    wr_slot = '0; wr_data = '0; r_finished = 1'b0;
    step(); step();
    chk("rst_r_rst", r_rst, 0);
    chk("rst_enable", r_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_sx", r_sx, 0);
    rst = 1'b0;
    step();

    // 1: single sprite in slot 0, exact latency
    wr(0, 1'b1, 3, 16, 100, 50);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("t1_c1_rrst", r_rst, 0);
    chk("t1_c1_busy", busy, 1);
    chk("t1_c1_en", r_enable, 0);
    step();
    chk("t1_c2_rrst", r_rst, 1);
    chk("t1_c2_en", r_enable, 0);
    chk("t1_sx", r_sx, 100);
    chk("t1_sy", r_sy, 50);
    chk("t1_scale", r_scale, 16);
    chk("t1_id", r_id, 3);
    step();
    chk("t1_c3_en", r_enable, 1);
    chk("t1_c3_rrst", r_rst, 0);
    step(); step();
    chk("t1_run_en", r_enable, 1);
    chk("t1_run_sx", r_sx, 100);
    r_finished = 1'b1;
    step();
    r_finished = 1'b0;
    chk("t1_en_drop", r_enable, 0);
    n = 0;
    while (!frame_done && n < 200) begin
      step();
      n++;
    end
    chk("t1_skips", n, 15);
    step();
    chk("t1_busy_low", busy, 0);

    // 2: slots 2 and 5, renderer finishes after 20 cycles
    wr(0, 1'b0, 0, 0, 0, 0);
    wr(2, 1'b1, 1, 8, 10, 20);
    wr(5, 1'b1, 2, 4, 30, 40);
    run_frame(20, 0);
    chk("t2_nrst", n_rst, 2);
    chk("t2_first", sx_q.size() > 0 ? sx_q[0] : -1, 10);
    chk("t2_second", sx_q.size() > 1 ? sx_q[1] : -1, 30);
    chk("t2_ndone", n_done, 1);
    chk("t2_busy", busy_after, 0);
    chk("t2_clash", clash, 0);
    chk("t2_tmo", n_tmo, 0);
    chk("t2_idle_en", en_after, 0);

    // 3: write coinciding with frame_start lands next frame only
    wr(2, 1'b0, 0, 0, 0, 0);
    wr(5, 1'b0, 0, 0, 0, 0);
    wr_en   = 1'b1;
    wr_slot = 4'd1;
    wr_data = {1'b1, 4'd5, 8'd2, 10'd60, 10'd70};
    run_frame(20, 0);
    chk("t3a_nrst", n_rst, 0);
    chk("t3a_len", done_cyc, 17);
    run_frame(20, 0);
    chk("t3b_nrst", n_rst, 1);
    chk("t3b_sx", sx_q.size() > 0 ? sx_q[0] : -1, 70);

    // 4: frame_start mid-RUN
    run_frame(20, 6);
    chk("t4_ovr", n_ovr, 1);
    chk("t4_ndone", n_done, 1);
    chk("t4_nrst", n_rst, 1);
    chk("t4_busy", busy_after, 0);

    // 5: renderer never finishes
    wr(9, 1'b1, 7, 1, 90, 9);
    run_frame(0, 0);
    chk("t5_tmo", n_tmo, 2);
    chk("t5_nrst", n_rst, 2);
    chk("t5_en_cyc", n_en, 2*TMO);
    chk("t5_second", sx_q.size() > 1 ? sx_q[1] : -1, 90);
    chk("t5_ndone", n_done, 1);

    // 6: reset during RUN
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    n = 0;
    while (!r_enable && n < 50) begin
      step();
      n++;
    end
    chk("t6_run", r_enable, 1);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_en", r_enable, 0);
    chk("t6_busy", busy, 0);
    chk("t6_rrst", r_rst, 0);
    chk("t6_sx", r_sx, 0);
    step();
    run_frame(20, 0);
    chk("t6_nrst", n_rst, 0);
    chk("t6_len", done_cyc, 17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
